dft_scan_buf: RTL
=================

// Module: dft_scan_buf
// PURPOSE
// - 32-bit scan capture/dump buffer; sits directly downstream of the DFT controller, between it and the DUT scan chain.
// - Write op: shifts 32 bits out of the chain, captured LSB-first, and stores the word in an internal RAM.
// - Read op: returns stored words in order on dout for the host-side DFT output path.
// - Optional loopback of chain_so to chain_si, so the scan capture preserves DUT state.
// PARAMETERS
// - ADDR_W  10  log2 of word capacity (DEPTH = 2**ADDR_W words of 32 bits)
// PORTS
// clk            in   1   clock
// reset          in   1   synchronous, active-high; clears all state
// buf_op         in   1   op select: 0 = WR (scan-capture), 1 = RD (dump)
// buf_sin_sel    in   1   chain_si source: 0 = constant 0, 1 = chain_so loopback
// buf_val_op     in   1   op request (level)
// buf_reset      in   1   pointer reset / abort (see BEHAVIOUR)
// buf_op_ack     out  1   op accepted (combinational)
// buf_op_commit  out  1   op complete, one-cycle pulse
// buf_scaning    out  1   shift enable to scan chain (combinational)
// chain_so       in   1   DUT scan-chain serial out
// chain_si       out  1   DUT scan-chain serial in
// dout           out  32  last word read; registered
// word_cnt       out  ADDR_W+1  words stored (= wr_ptr)
// ovf            out  1   sticky: WR commit attempted while full
// udf            out  1   sticky: RD attempted at rd_ptr >= wr_ptr
// BEHAVIOUR
// - Reset values: state IDLE; wr_ptr = rd_ptr = bitcnt = 0; shreg = 0; dout = 0; ovf = udf = 0; all handshake outputs 0.
// - chain_si = buf_sin_sel ? chain_so : 1'b0, combinational in every state.
// - FSM states: IDLE, SHIFT, WCOMMIT, RWAIT, RCOMMIT.
// - IDLE:
//   - buf_op_ack = buf_val_op & ~buf_reset (same cycle).
//   - On ack with op = WR: go to SHIFT.
//   - On ack with op = RD: issue RAM read at rd_ptr and go to RWAIT.
// - SHIFT:
//   - buf_scaning = ~buf_reset.
//   - Each cycle: shreg <= {chain_so, shreg[31:1]}; bitcnt++.
//   - After exactly 32 scaning cycles (bitcnt reaches 31 and shifts): go to WCOMMIT.
// - WCOMMIT (1 cycle):
//   - buf_op_commit = 1.
//   - If wr_ptr < DEPTH: RAM[wr_ptr] <= shreg; wr_ptr++. Otherwise set ovf and drop the word.
//   - bitcnt <= 0. Go to IDLE.
// - RWAIT (1 cycle): RAM registered-read latency.
//   - End of cycle: dout <= (rd_ptr < wr_ptr) ? rdata : 32'h0.
//   - Underflow case sets udf.
// - RCOMMIT (1 cycle): buf_op_commit = 1; rd_ptr++ (saturates at DEPTH). Go to IDLE.
// - Read latency: ack at cycle A, commit at A+2; dout is valid from A+2 and held until the next read's RWAIT.
// - buf_reset has priority over everything and forces IDLE next cycle. Action depends on buf_op:
//   - WR: wr_ptr <= 0; bitcnt <= 0; ovf <= 0. Partial word discarded.
//   - RD: if bitcnt in 1..31 (aborted mid-word), flush {zero-pad, captured bits} as a right-aligned word:
//     RAM[wr_ptr] <= shreg >> (32 - bitcnt); wr_ptr++. Then bitcnt <= 0; rd_ptr <= 0; udf <= 0.
//   - No commit pulse is produced for a reset-aborted op.
// - buf_val_op outside IDLE is ignored; no queuing.
// - Simultaneous buf_reset & buf_val_op: reset wins; no ack.
// - word_cnt saturates at DEPTH. The RAM is not cleared on reset; contents beyond wr_ptr are never returned.
// STRUCTURE
// - Package dft_pkg: BUF_WR = 1'b0, BUF_RD = 1'b1, SIN_ZERO = 1'b0, SIN_DUT = 1'b1, FSM state enum (3-bit).
// - Sub-module dft_buf_ram: 1W1R, DEPTH x 32, synchronous write, registered read; no reset.
// TESTING
// - WR from IDLE, chain_so = bit i of 32'hA5A5_0F0F at shift i -> ack same cycle; scaning high exactly 32 cycles;
//   commit on cycle 33; word_cnt = 1.
// - Then buf_reset with op = RD, followed by an RD op -> commit 2 cycles after ack; dout = 32'hA5A5_0F0F; rd_ptr = 1.
// - WR aborted after 5 shifts of 1'b1 by buf_reset with op = RD -> word 32'h0000_001F appended; no commit pulse; word_cnt incremented.
// - ADDR_W = 2, five WR ops -> word_cnt = 4; ovf = 1 after the 5th commit; 5th word dropped.
// - RD with rd_ptr == wr_ptr -> dout = 0; udf = 1; commit still pulses.
// - buf_sin_sel = 1 for 32 shifts -> chain_si tracks chain_so every cycle.
// - buf_sin_sel = 0 -> chain_si = 0.
// - Synchronous reset asserted mid-SHIFT -> next cycle IDLE; all outputs at reset values; scaning low.

Source files
------------

// File: rtl/dft_pkg.sv
// Shared definitions for the DFT scan capture/dump buffer.
//   - op / serial-in select encodings used on buf_op and buf_sin_sel
//   - buffer FSM state encoding
//   - right_align(): turns a partially captured word into a zero-padded,
//     right-aligned word
package dft_pkg;

    localparam int WORD_W = 32;
    localparam int BCNT_W = 5;   // log2(WORD_W): bit counter within a word

    localparam logic BUF_WR   = 1'b0;   // scan-capture into the buffer
    localparam logic BUF_RD   = 1'b1;   // dump a stored word on dout
    localparam logic SIN_ZERO = 1'b0;   // chain_si driven low
    localparam logic SIN_DUT  = 1'b1;   // chain_si loops chain_so back

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SHIFT   = 3'd1,
        S_WCOMMIT = 3'd2,
        S_RWAIT   = 3'd3,
        S_RCOMMIT = 3'd4
    } buf_state_t;

    // Write request into the word RAM.
    typedef struct packed {
        logic              we;
        logic [WORD_W-1:0] wdata;
    } ram_wr_t;

    // Bits enter the shift register at the MSB, so after n shifts the
    // captured bits sit in [31 -: n]. Shifting right by 32-n puts the first
    // captured bit at bit 0 and zero-fills above. n must be 1..31.
    function automatic logic [WORD_W-1:0] right_align(
        input logic [WORD_W-1:0] sh,
        input logic [BCNT_W-1:0] n
    );
        logic [BCNT_W:0] amt;
        amt = 6'd32 - {1'b0, n};
        return sh >> amt;
    endfunction

endpackage

// File: rtl/dft_buf_ram.sv
// Word storage for the scan buffer: one write port, one read port.
//   clk    in   clock
//   we     in   write enable (synchronous write)
//   waddr  in   write address
//   wdata  in   write data
//   re     in   read enable; rdata updates on the next edge
//   raddr  in   read address
//   rdata  out  registered read data, held while re is low
// No reset: contents are only ever returned after being written.
module dft_buf_ram
    import dft_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/dft_scan_buf.sv
// 32-bit scan capture/dump buffer between the DFT controller and the DUT
// scan chain.
//   WR op : shifts 32 bits out of chain_so (LSB first) and appends the word
//           to the internal RAM.
//   RD op : returns stored words in order on dout (registered, held).
// Ports:
//   clk, reset         clock; synchronous active-high reset of all state
//   buf_op             0 = WR, 1 = RD
//   buf_sin_sel        chain_si source: 0 = constant 0, 1 = chain_so loopback
//   buf_val_op         op request level, only sampled in IDLE
//   buf_reset          pointer reset / abort, qualified by buf_op
//   buf_op_ack         op accepted (combinational)
//   buf_op_commit      op complete, one-cycle pulse
//   buf_scaning        shift enable to the scan chain (combinational)
//   chain_so/chain_si  scan chain serial out / in
//   dout               last word read
//   word_cnt           words stored (write pointer)
//   ovf, udf           sticky overflow / underflow flags
module dft_scan_buf
    import dft_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              buf_op,
    input  logic              buf_sin_sel,
    input  logic              buf_val_op,
    input  logic              buf_reset,
    output logic              buf_op_ack,
    output logic              buf_op_commit,
    output logic              buf_scaning,
    input  logic              chain_so,
    output logic              chain_si,
    output logic [WORD_W-1:0] dout,
    output logic [ADDR_W:0]   word_cnt,
    output logic              ovf,
    output logic              udf
);

    localparam logic [ADDR_W:0] DEPTH_V = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);

    buf_state_t        state, state_nx;
    logic [ADDR_W:0]   wr_ptr, rd_ptr;
    logic [BCNT_W-1:0] bitcnt;
    logic [WORD_W-1:0] shreg;
    logic [WORD_W-1:0] rdata;
    logic              rd_en;
    logic              full;
    logic              rd_ok;
    logic              wcommit;
    logic              flush;
    ram_wr_t           wr_req;

    assign chain_si = (buf_sin_sel == SIN_DUT) ? chain_so : 1'b0;
    assign word_cnt = wr_ptr;

    assign full    = (wr_ptr >= DEPTH_V);
    assign rd_ok   = (rd_ptr < wr_ptr);
    assign wcommit = (state == S_WCOMMIT) && !buf_reset;
    // An RD-qualified buf_reset with a partial word in the shift register
    // saves the bits captured so far instead of discarding them.
    assign flush   = buf_reset && (buf_op == BUF_RD) && (bitcnt != '0);

    always_comb begin
        wr_req.we    = (wcommit || flush) && !full;
        wr_req.wdata = flush ? right_align(shreg, bitcnt) : shreg;
    end

    dft_buf_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .we    (wr_req.we),
        .waddr (wr_ptr[ADDR_W-1:0]),
        .wdata (wr_req.wdata),
        .re    (rd_en),
        .raddr (rd_ptr[ADDR_W-1:0]),
        .rdata (rdata)
    );

    // Next state and handshake outputs. buf_reset masks every output and
    // returns the FSM to IDLE.
    always_comb begin
        state_nx      = state;
        buf_op_ack    = 1'b0;
        buf_op_commit = 1'b0;
        buf_scaning   = 1'b0;
        rd_en         = 1'b0;
        if (buf_reset) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (buf_val_op) begin
                        buf_op_ack = 1'b1;
                        if (buf_op == BUF_WR) begin
                            state_nx = S_SHIFT;
                        end else begin
                            rd_en    = 1'b1;
                            state_nx = S_RWAIT;
                        end
                    end
                end
                S_SHIFT: begin
                    buf_scaning = 1'b1;
                    if (bitcnt == 5'd31) begin
                        state_nx = S_WCOMMIT;
                    end
                end
                S_WCOMMIT: begin
                    buf_op_commit = 1'b1;
                    state_nx      = S_IDLE;
                end
                S_RWAIT: begin
                    state_nx = S_RCOMMIT;
                end
                S_RCOMMIT: begin
                    buf_op_commit = 1'b1;
                    state_nx      = S_IDLE;
                end
                default: begin
                    state_nx = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            bitcnt <= '0;
            shreg  <= '0;
            dout   <= '0;
            ovf    <= 1'b0;
            udf    <= 1'b0;
        end else begin
            state <= state_nx;
            if (buf_reset) begin
                bitcnt <= '0;
                if (buf_op == BUF_WR) begin
                    wr_ptr <= '0;
                    ovf    <= 1'b0;
                end else begin
                    if (wr_req.we) begin
                        wr_ptr <= wr_ptr + PTR_ONE;
                    end
                    rd_ptr <= '0;
                    udf    <= 1'b0;
                end
            end else begin
                if (buf_scaning) begin
                    shreg  <= {chain_so, shreg[WORD_W-1:1]};
                    bitcnt <= bitcnt + 5'd1;   // wraps to 0 after the 32nd bit
                end
                if (wcommit) begin
                    bitcnt <= '0;
                    if (full) begin
                        ovf <= 1'b1;
                    end else begin
                        wr_ptr <= wr_ptr + PTR_ONE;
                    end
                end
                if (state == S_RWAIT) begin
                    // Never expose RAM contents beyond the write pointer.
                    dout <= rd_ok ? rdata : '0;
                    if (!rd_ok) begin
                        udf <= 1'b1;
                    end
                end
                if ((state == S_RCOMMIT) && (rd_ptr < DEPTH_V)) begin
                    rd_ptr <= rd_ptr + PTR_ONE;
                end
            end
        end
    end

endmodule
